tm_qm_ctrl: RTL and testbench

TM_QM_CTRL -- requirements
Module: tm_qm_ctrl

---
 rtl/tm_qm_ctrl_if.sv | 107 ++++++++++
 rtl/tm_qm_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_tm_qm_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tm_qm_ctrl_if.sv
// tm_qm_ctrl_if -- bundle of all non-clock signals of the queue-manager
// controller: enqueue/dequeue request handshakes, completion pulses and the
// 1r1w RAM ports (head, tail, depth, depth1, ll, pkt_desc).
//
// Handshake rule for both request channels: a request transfers on a rising
// clk edge where valid && ready are both high; the request fields must be
// stable whenever valid is high and are captured at that edge. The ready
// signals may depend combinationally on the valids.
//
// Modports:
//   slave  - the controller (accepts requests, drives the RAM ports)
//   master - the requester / RAM environment
`ifndef SECOND_LVL_QUEUE_ID_NBITS
`define SECOND_LVL_QUEUE_ID_NBITS 4
`endif
`ifndef TM_QM_DESC_TYPE_DEFINED
`define TM_QM_DESC_TYPE_DEFINED
typedef logic [31:0] sch_pkt_desc_type;
`endif

interface tm_qm_ctrl_if #(
    parameter int QUEUE_ID_NBITS      = `SECOND_LVL_QUEUE_ID_NBITS,
    parameter int QUEUE_ENTRIES_NBITS = `SECOND_LVL_QUEUE_ID_NBITS
);
    localparam int QW = QUEUE_ID_NBITS;
    localparam int EW = QUEUE_ENTRIES_NBITS;

    // enqueue channel
    logic             enq_valid;
    logic             enq_ready;
    logic [QW-1:0]    enq_qid;
    logic [EW-1:0]    enq_ptr;
    sch_pkt_desc_type enq_desc;
    logic             enq_done;
    logic             enq_drop;
    // dequeue channel
    logic             deq_valid;
    logic             deq_ready;
    logic [QW-1:0]    deq_qid;
    logic             deq_done;
    logic             deq_empty;
    logic [EW-1:0]    deq_ptr;
    logic [EW-1:0]    deq_depth;
    sch_pkt_desc_type deq_desc;
    logic             busy;
    // head RAM: queue -> first entry
    logic             head_wr;
    logic [QW-1:0]    head_raddr;
    logic [QW-1:0]    head_waddr;
    logic [EW-1:0]    head_wdata;
    logic [EW-1:0]    head_rdata;
    // tail RAM: queue -> last entry
    logic             tail_wr;
    logic [QW-1:0]    tail_raddr;
    logic [QW-1:0]    tail_waddr;
    logic [EW-1:0]    tail_wdata;
    logic [EW-1:0]    tail_rdata;
    // depth RAM: queue -> entry count
    logic             depth_wr;
    logic [QW-1:0]    depth_raddr;
    logic [QW-1:0]    depth_waddr;
    logic [EW-1:0]    depth_wdata;
    logic [EW-1:0]    depth_rdata;
    // second depth RAM port set, unused by this controller (tied off)
    logic             depth1_wr;
    logic [QW-1:0]    depth1_raddr;
    logic [QW-1:0]    depth1_waddr;
    logic [EW-1:0]    depth1_wdata;
    // link-list RAM: entry -> next entry
    logic             ll_wr;
    logic [EW-1:0]    ll_raddr;
    logic [EW-1:0]    ll_waddr;
    logic [EW-1:0]    ll_wdata;
    logic [EW-1:0]    ll_rdata;
    // descriptor RAM: entry -> descriptor
    logic             pkt_desc_wr;
    logic [EW-1:0]    pkt_desc_raddr;
    logic [EW-1:0]    pkt_desc_waddr;
    sch_pkt_desc_type pkt_desc_wdata;
    sch_pkt_desc_type pkt_desc_rdata;

    modport slave (
        input  enq_valid, enq_qid, enq_ptr, enq_desc, deq_valid, deq_qid,
               head_rdata, tail_rdata, depth_rdata, ll_rdata, pkt_desc_rdata,
        output enq_ready, enq_done, enq_drop,
               deq_ready, deq_done, deq_empty, deq_ptr, deq_depth, deq_desc, busy,
               head_wr, head_raddr, head_waddr, head_wdata,
               tail_wr, tail_raddr, tail_waddr, tail_wdata,
               depth_wr, depth_raddr, depth_waddr, depth_wdata,
               depth1_wr, depth1_raddr, depth1_waddr, depth1_wdata,
               ll_wr, ll_raddr, ll_waddr, ll_wdata,
               pkt_desc_wr, pkt_desc_raddr, pkt_desc_waddr, pkt_desc_wdata
    );

    modport master (
        output enq_valid, enq_qid, enq_ptr, enq_desc, deq_valid, deq_qid,
               head_rdata, tail_rdata, depth_rdata, ll_rdata, pkt_desc_rdata,
        input  enq_ready, enq_done, enq_drop,
               deq_ready, deq_done, deq_empty, deq_ptr, deq_depth, deq_desc, busy,
               head_wr, head_raddr, head_waddr, head_wdata,
               tail_wr, tail_raddr, tail_waddr, tail_wdata,
               depth_wr, depth_raddr, depth_waddr, depth_wdata,
               depth1_wr, depth1_raddr, depth1_waddr, depth1_wdata,
               ll_wr, ll_raddr, ll_waddr, ll_wdata,
               pkt_desc_wr, pkt_desc_raddr, pkt_desc_waddr, pkt_desc_wdata
    );
endinterface

// File: rtl/tm_qm_ctrl.sv
// tm_qm_ctrl -- linked-list queue manager controller.
//
// Keeps many FIFO queues of entry pointers in external 1r1w RAMs (head, tail,
// depth per queue; next-pointer per entry; descriptor per entry). One
// enqueue or dequeue is processed at a time; simultaneous requests are
// arbitrated round-robin, enqueue first after reset.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus          tm_qm_ctrl_if.slave: request channels, completion pulses,
//                RAM ports (all RAM reads have 1-cycle latency)
//   dbg_state_o  current FSM state encoding
//
// Timing (transfer edge = cycle 0):
//   enqueue : ENQ_RD (cycle 1), ENQ_WR (cycle 2, enq_done/enq_drop)
//   dequeue : DEQ_RD (cycle 1), DEQ_LL (cycle 2, deq_empty), DEQ_WR (cycle 3,
//             deq_done)
`ifndef SECOND_LVL_QUEUE_ID_NBITS
`define SECOND_LVL_QUEUE_ID_NBITS 4
`endif
`ifndef TM_QM_DESC_TYPE_DEFINED
`define TM_QM_DESC_TYPE_DEFINED
typedef logic [31:0] sch_pkt_desc_type;
`endif

module tm_qm_ctrl #(
    parameter int QUEUE_ID_NBITS      = `SECOND_LVL_QUEUE_ID_NBITS,
    parameter int QUEUE_ENTRIES_NBITS = `SECOND_LVL_QUEUE_ID_NBITS
) (
    input  logic               clk,
    input  logic               rst_n,
    tm_qm_ctrl_if.slave        bus,
    output logic [2:0]         dbg_state_o
);
    localparam int QW = QUEUE_ID_NBITS;
    localparam int EW = QUEUE_ENTRIES_NBITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENQ_RD = 3'd1,
        ENQ_WR = 3'd2,
        DEQ_RD = 3'd3,
        DEQ_LL = 3'd4,
        DEQ_WR = 3'd5
    } state_t;

    state_t           state_q;
    logic [QW-1:0]    qid_q;
    logic [EW-1:0]    ptr_q;
    sch_pkt_desc_type desc_q;
    logic [EW-1:0]    head_q;
    logic [EW-1:0]    depth_q;
    logic             last_deq_q;     // 1: last grant went to dequeue
    logic [EW-1:0]    deq_ptr_q;
    logic [EW-1:0]    deq_depth_q;
    sch_pkt_desc_type deq_desc_q;

    logic          grant_enq;
    logic          grant_deq;
    logic          idle_ok;
    logic          enq_fire;
    logic          deq_fire;
    logic          depth_zero;
    logic          depth_full;
    logic [EW-1:0] depth_dec;

    // Round-robin: with both requesting, the side not granted last wins.
    assign grant_enq  = bus.enq_valid && (!bus.deq_valid || last_deq_q);
    assign grant_deq  = bus.deq_valid && (!bus.enq_valid || !last_deq_q);
    assign idle_ok    = rst_n && (state_q == IDLE);
    assign bus.enq_ready = idle_ok && grant_enq;
    assign bus.deq_ready = idle_ok && grant_deq;
    assign enq_fire   = bus.enq_valid && bus.enq_ready;
    assign deq_fire   = bus.deq_valid && bus.deq_ready;

    assign depth_zero = (bus.depth_rdata == '0);
    assign depth_full = (bus.depth_rdata == '1);
    assign depth_dec  = depth_q - 1'b1;

    assign bus.busy   = (state_q != IDLE);
    assign dbg_state_o = state_q;

    // Per-queue reads always address the captured queue; the RAM data is
    // only consumed in the state following ENQ_RD / DEQ_RD.
    assign bus.head_raddr  = qid_q;
    assign bus.tail_raddr  = qid_q;
    assign bus.depth_raddr = qid_q;
    // Entry reads follow the head pointer as it arrives in DEQ_LL.
    assign bus.ll_raddr       = (state_q == DEQ_LL) ? bus.head_rdata : head_q;
    assign bus.pkt_desc_raddr = (state_q == DEQ_LL) ? bus.head_rdata : head_q;

    assign bus.depth1_wr    = 1'b0;
    assign bus.depth1_raddr = '0;
    assign bus.depth1_waddr = '0;
    assign bus.depth1_wdata = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            qid_q       <= '0;
            ptr_q       <= '0;
            desc_q      <= '0;
            head_q      <= '0;
            depth_q     <= '0;
            last_deq_q  <= 1'b1;
            deq_ptr_q   <= '0;
            deq_depth_q <= '0;
            deq_desc_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enq_fire) begin
                        qid_q      <= bus.enq_qid;
                        ptr_q      <= bus.enq_ptr;
                        desc_q     <= bus.enq_desc;
                        last_deq_q <= 1'b0;
                        state_q    <= ENQ_RD;
                    end else if (deq_fire) begin
                        qid_q      <= bus.deq_qid;
                        last_deq_q <= 1'b1;
                        state_q    <= DEQ_RD;
                    end
                end
                ENQ_RD: state_q <= ENQ_WR;
                ENQ_WR: state_q <= IDLE;
                DEQ_RD: state_q <= DEQ_LL;
                DEQ_LL: begin
                    if (depth_zero) begin
                        state_q <= IDLE;
                    end else begin
                        head_q  <= bus.head_rdata;
                        depth_q <= bus.depth_rdata;
                        state_q <= DEQ_WR;
                    end
                end
                DEQ_WR: begin
                    deq_ptr_q   <= head_q;
                    deq_depth_q <= depth_dec;
                    deq_desc_q  <= bus.pkt_desc_rdata;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Writes and completion pulses depend on RAM read data that only exists
    // in the write state, so they are decoded from the current state. All of
    // them are gated by rst_n so a reset aborts without touching memory.
    always_comb begin
        bus.head_wr        = 1'b0;
        bus.head_waddr     = qid_q;
        bus.head_wdata     = ptr_q;
        bus.tail_wr        = 1'b0;
        bus.tail_waddr     = qid_q;
        bus.tail_wdata     = ptr_q;
        bus.depth_wr       = 1'b0;
        bus.depth_waddr    = qid_q;
        bus.depth_wdata    = '0;
        bus.ll_wr          = 1'b0;
        bus.ll_waddr       = bus.tail_rdata;
        bus.ll_wdata       = ptr_q;
        bus.pkt_desc_wr    = 1'b0;
        bus.pkt_desc_waddr = ptr_q;
        bus.pkt_desc_wdata = desc_q;
        bus.enq_done       = 1'b0;
        bus.enq_drop       = 1'b0;
        bus.deq_done       = 1'b0;
        bus.deq_empty      = 1'b0;
        bus.deq_ptr        = deq_ptr_q;
        bus.deq_depth      = deq_depth_q;
        bus.deq_desc       = deq_desc_q;
        if (rst_n) begin
            case (state_q)
                ENQ_WR: begin
                    if (depth_full) begin
                        bus.enq_drop = 1'b1;
                    end else begin
                        bus.tail_wr     = 1'b1;
                        bus.depth_wr    = 1'b1;
                        bus.depth_wdata = bus.depth_rdata + 1'b1;
                        bus.pkt_desc_wr = 1'b1;
                        // Empty queue: new entry becomes head; otherwise it
                        // is linked behind the old tail.
                        bus.head_wr     = depth_zero;
                        bus.ll_wr       = !depth_zero;
                        bus.enq_done    = 1'b1;
                    end
                end
                DEQ_LL: begin
                    bus.deq_empty = depth_zero;
                end
                DEQ_WR: begin
                    bus.depth_wr    = 1'b1;
                    bus.depth_wdata = depth_dec;
                    // Last entry leaves: head is stale but ignored at depth 0.
                    bus.head_wr     = (depth_dec != '0);
                    bus.head_wdata  = bus.ll_rdata;
                    bus.deq_done    = 1'b1;
                    bus.deq_ptr     = head_q;
                    bus.deq_depth   = depth_dec;
                    bus.deq_desc    = bus.pkt_desc_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tm_qm_ctrl.sv
`ifndef SECOND_LVL_QUEUE_ID_NBITS
`define SECOND_LVL_QUEUE_ID_NBITS 4
`endif
`ifndef TM_QM_DESC_TYPE_DEFINED
`define TM_QM_DESC_TYPE_DEFINED
typedef logic [31:0] sch_pkt_desc_type;
`endif

module tb_tm_qm_ctrl;
    localparam int QW = 4;
    localparam int EW = 4;
    localparam int DW = 32;
    localparam int NQ = 1 << QW;
    localparam int NE = 1 << EW;
    localparam int RW = 2 + EW + EW + DW;      // {kind, ptr, depth, desc}
    localparam int MAXD = (1 << EW) - 1;
    localparam logic [1:0] K_ENQ_DONE = 2'd0;
    localparam logic [1:0] K_ENQ_DROP = 2'd1;
    localparam logic [1:0] K_DEQ_DONE = 2'd2;
    localparam logic [1:0] K_DEQ_EMPTY = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] dbg_state;
    int cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tm_qm_ctrl_if #(.QUEUE_ID_NBITS(QW), .QUEUE_ENTRIES_NBITS(EW)) bus ();

    tm_qm_ctrl #(.QUEUE_ID_NBITS(QW), .QUEUE_ENTRIES_NBITS(EW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- RAM models (1-cycle read latency) ----------------
    logic [EW-1:0]    head_mem [NQ];
    logic [EW-1:0]    tail_mem [NQ];
    logic [EW-1:0]    depth_mem[NQ];
    logic [EW-1:0]    ll_mem   [NE];
    sch_pkt_desc_type desc_mem [NE];
    int wr_cnt = 0;

    always @(posedge clk) begin
        if (bus.head_wr)     head_mem[bus.head_waddr]     <= bus.head_wdata;
        if (bus.tail_wr)     tail_mem[bus.tail_waddr]     <= bus.tail_wdata;
        if (bus.depth_wr)    depth_mem[bus.depth_waddr]   <= bus.depth_wdata;
        if (bus.ll_wr)       ll_mem[bus.ll_waddr]         <= bus.ll_wdata;
        if (bus.pkt_desc_wr) desc_mem[bus.pkt_desc_waddr] <= bus.pkt_desc_wdata;
        bus.head_rdata     <= head_mem[bus.head_raddr];
        bus.tail_rdata     <= tail_mem[bus.tail_raddr];
        bus.depth_rdata    <= depth_mem[bus.depth_raddr];
        bus.ll_rdata       <= ll_mem[bus.ll_raddr];
        bus.pkt_desc_rdata <= desc_mem[bus.pkt_desc_raddr];
        wr_cnt <= wr_cnt + int'(bus.head_wr) + int'(bus.tail_wr) + int'(bus.depth_wr)
                  + int'(bus.ll_wr) + int'(bus.pkt_desc_wr) + int'(bus.depth1_wr);
    end

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    int            due_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: one global FIFO of {qid, ptr, desc}; a queue's contents are
    // its entries in arrival order, its depth is how many there are.
    logic [QW+EW+DW-1:0] ref_q[$];

    function automatic int model_depth(input logic [QW-1:0] q);
        int n = 0;
        foreach (ref_q[i]) if (ref_q[i][QW+EW+DW-1 -: QW] == q) n++;
        return n;
    endfunction

    function automatic logic [RW-1:0] model_enq(input logic [QW-1:0] q, input logic [EW-1:0] p,
                                               input sch_pkt_desc_type d);
        if (model_depth(q) == MAXD) return {K_ENQ_DROP, {(RW-2){1'b0}}};
        ref_q.push_back({q, p, d});
        return {K_ENQ_DONE, {(RW-2){1'b0}}};
    endfunction

    function automatic logic [RW-1:0] model_deq(input logic [QW-1:0] q);
        logic [QW+EW+DW-1:0] e;
        int left;
        for (int i = 0; i < ref_q.size(); i++) begin
            if (ref_q[i][QW+EW+DW-1 -: QW] == q) begin
                e = ref_q[i];
                ref_q.delete(i);
                left = model_depth(q);
                return {K_DEQ_DONE, e[EW+DW-1 -: EW], left[EW-1:0], e[DW-1:0]};
            end
        end
        return {K_DEQ_EMPTY, {(RW-2){1'b0}}};
    endfunction

    function automatic int lat_of(input logic [1:0] k);
        return (k == K_DEQ_DONE) ? 3 : 2;
    endfunction

    // Called at the negedge before the transfer edge.
    task automatic expect_op(input bit is_enq, input logic [QW-1:0] q, input logic [EW-1:0] p,
                             input sch_pkt_desc_type d, input bit force_drop);
        logic [RW-1:0] e;
        if (!is_enq)         e = model_deq(q);
        else if (force_drop) e = {K_ENQ_DROP, {(RW-2){1'b0}}};
        else                 e = model_enq(q, p, d);
        exp_q.push_back(e);
        due_q.push_back(cyc + lat_of(e[RW-1 -: 2]));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [1:0]    k;
        logic [RW-1:0] act;
        logic [RW-1:0] e;
        int            due;
        if (bus.enq_done || bus.enq_drop || bus.deq_done || bus.deq_empty) begin
            if (bus.deq_done)       k = K_DEQ_DONE;
            else if (bus.deq_empty) k = K_DEQ_EMPTY;
            else if (bus.enq_drop)  k = K_ENQ_DROP;
            else                    k = K_ENQ_DONE;
            act = bus.deq_done ? {k, bus.deq_ptr, bus.deq_depth, bus.deq_desc}
                               : {k, {(RW-2){1'b0}}};
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: got %h expected none (cycle %0d)", act, cyc);
            end else begin
                e   = exp_q.pop_front();
                due = due_q.pop_front();
                check("resp", 64'(act), 64'(e));
                check("latency", 64'(cyc), 64'(due));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input bit is_enq, input logic [QW-1:0] q, input logic [EW-1:0] p,
                         input sch_pkt_desc_type d, input bit push, input bit force_drop,
                         output int t0);
        bit got = 1'b0;
        t0 = 0;
        if (is_enq) begin
            bus.enq_qid = q; bus.enq_ptr = p; bus.enq_desc = d; bus.enq_valid = 1'b1;
        end else begin
            bus.deq_qid = q; bus.deq_valid = 1'b1;
        end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (is_enq ? bus.enq_ready : bus.deq_ready) begin
                got = 1'b1;
                t0  = cyc;
                if (push) expect_op(is_enq, q, p, d, force_drop);
            end
        end
        if (!got) check("grant_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        bus.enq_valid = 1'b0;
        bus.deq_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
    endtask

    // Flags that must all be low in reset/abort: readies, busy, pulses, writes.
    function automatic logic [12:0] quiet_flags();
        return {bus.enq_ready, bus.deq_ready, bus.busy, bus.enq_done, bus.enq_drop,
                bus.deq_done, bus.deq_empty, bus.head_wr, bus.tail_wr, bus.depth_wr,
                bus.ll_wr, bus.pkt_desc_wr, bus.depth1_wr};
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.enq_valid = 1'b1;          // requests during reset must not be accepted
        bus.deq_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", 64'(quiet_flags()), 64'(0));
        check("rst_deq_out", 64'({bus.deq_ptr, bus.deq_depth, bus.deq_desc}), 64'(0));
        bus.enq_valid = 1'b0;
        bus.deq_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int snap;
        int grants;
        logic [EW-1:0] pool[$];
        bit used;
        logic [QW-1:0] q;

        foreach (head_mem[i]) begin
            head_mem[i] = '0; tail_mem[i] = '0; depth_mem[i] = '0;
        end
        foreach (ll_mem[i]) begin
            ll_mem[i] = '0; desc_mem[i] = '0;
        end
        bus.enq_valid = 1'b0; bus.enq_qid = '0; bus.enq_ptr = '0; bus.enq_desc = '0;
        bus.deq_valid = 1'b0; bus.deq_qid = '0;
        @(posedge clk); #1;
        apply_reset();

        // Both requesters held: grants alternate, enqueue first after reset.
        bus.enq_qid = 0; bus.enq_ptr = 10; bus.enq_desc = $urandom;
        bus.deq_qid = 0;
        bus.enq_valid = 1'b1; bus.deq_valid = 1'b1;
        grants = 0;
        for (int i = 0; i < 100 && grants < 6; i++) begin
            @(negedge clk);
            if (bus.enq_ready && bus.deq_ready) check("arb_both_ready", 64'(1), 64'(0));
            if (bus.enq_ready || bus.deq_ready) begin
                check("arb_grant", 64'(bus.deq_ready), 64'(grants % 2));
                expect_op(!bus.deq_ready, bus.enq_qid, bus.enq_ptr, bus.enq_desc, 1'b0);
                used = bus.enq_ready;
                grants++;
                @(posedge clk); #1;
                if (used) begin
                    bus.enq_ptr  = bus.enq_ptr + 1'b1;
                    bus.enq_desc = $urandom;
                end
            end
        end
        if (grants < 6) check("arb_timeout", 64'(grants), 64'(6));
        bus.enq_valid = 1'b0; bus.deq_valid = 1'b0;
        wait_idle();

        // Two entries through q3 in FIFO order.
        issue(1'b1, 3, 5, 32'hA5A5_0005, 1'b1, 1'b0, t0);
        issue(1'b1, 3, 9, 32'h5A5A_0009, 1'b1, 1'b0, t0);
        issue(1'b0, 3, 0, 0, 1'b1, 1'b0, t0);
        issue(1'b0, 3, 0, 0, 1'b1, 1'b0, t0);
        wait_idle();
        check("q3_head_kept", 64'(head_mem[3]), 64'(9));
        check("q3_depth", 64'(depth_mem[3]), 64'(0));

        // Empty queue pop: deq_empty, no writes.
        snap = wr_cnt;
        issue(1'b0, 7, 0, 0, 1'b1, 1'b0, t0);
        wait_idle();
        check("empty_no_wr", 64'(wr_cnt), 64'(snap));

        // Full queue push: enq_drop, no writes.
        depth_mem[2] = '1;
        snap = wr_cnt;
        issue(1'b1, 2, 4, 32'hDEAD_BEEF, 1'b1, 1'b1, t0);
        wait_idle();
        check("drop_no_wr", 64'(wr_cnt), 64'(snap));
        check("drop_depth_kept", 64'(depth_mem[2]), 64'(MAXD));
        depth_mem[2] = '0;

        // Reset while the dequeue sits in DEQ_LL: aborted, queue untouched.
        issue(1'b1, 1, 6, 32'h1234_5678, 1'b1, 1'b0, t0);
        wait_idle();
        issue(1'b0, 1, 0, 0, 1'b0, 1'b0, t0);
        while (cyc < t0 + 2) @(negedge clk);
        check("abort_busy_before", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        snap = wr_cnt;
        @(posedge clk); #1;
        check("abort_flags", 64'(quiet_flags()), 64'(0));
        check("abort_deq_out", 64'({bus.deq_ptr, bus.deq_depth, bus.deq_desc}), 64'(0));
        @(posedge clk); #1;
        check("abort_no_wr", 64'(wr_cnt), 64'(snap));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Random traffic over four queues.
        for (int n = 0; n < 250; n++) begin
            q = QW'($urandom_range(0, 3));
            pool.delete();
            for (int e = 0; e < NE; e++) begin
                used = 1'b0;
                foreach (ref_q[i]) if (ref_q[i][EW+DW-1 -: EW] == EW'(e)) used = 1'b1;
                if (!used) pool.push_back(EW'(e));
            end
            if (pool.size() > 0 && $urandom_range(0, 1) == 1)
                issue(1'b1, q, pool[$urandom_range(0, pool.size() - 1)], $urandom, 1'b1, 1'b0, t0);
            else
                issue(1'b0, q, 0, 0, 1'b1, 1'b0, t0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
        check("drain", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
